case3_solver: RTL

CASE3_SOLVER -- requirements
Module: case3_solver

---
 rtl/case3_pkg.sv | 21 ++
 rtl/case3_eval.sv | 17 +
 rtl/case3_solver.sv | 123 ++++++++++++
 3 files changed

// File: rtl/case3_pkg.sv
// Shared types and constants for the case3 preimage solver.
package case3_pkg;

  localparam int VEC_W    = 7;
  localparam int N_VEC    = 128;
  localparam int TRIPLE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Output triple {x,y,z}; x is the MSB.
  typedef struct packed {
    logic x;
    logic y;
    logic z;
  } triple_t;

endpackage

// File: rtl/case3_eval.sv
// Combinational case3 network: seven inputs {a..g} (a = MSB) to the triple {x,y,z}.
module case3_eval
  import case3_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output triple_t          out_o
);

  logic a, b, c, d, e, f, g;

  assign {a, b, c, d, e, f, g} = vec_i;

  assign out_o.x = a & b & c & d & e;
  assign out_o.y = b | c | (b ^ d ^ f) | (d ^ e ^ f ^ g);
  assign out_o.z = c ^ d ^ (c & e & g) ^ (a & b & e & g);

endmodule

// File: rtl/case3_solver.sv
// Sequential preimage search over all 128 case3 input vectors, with
// first-match or full-sweep counting modes, abort and ack handshake.
module case3_solver
  import case3_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TRIPLE_W-1:0] target,
  input  logic                cnt_mode,
  input  logic                abort,
  input  logic                ack,
  output logic                ready,
  output logic                busy,
  output logic                valid,
  output logic                found,
  output logic [VEC_W-1:0]    vec,
  output logic [CNT_W-1:0]    count
);

  state_t           state_q,  state_d;
  logic [VEC_W-1:0] idx_q,    idx_d;
  triple_t          target_q, target_d;
  logic             mode_q,   mode_d;
  logic             found_q,  found_d;
  logic [VEC_W-1:0] vec_q,    vec_d;
  logic [CNT_W-1:0] count_q,  count_d;

  triple_t eval_out;
  logic    hit;
  logic    last_idx;

  case3_eval u_eval (
    .vec_i (idx_q),
    .out_o (eval_out)
  );

  assign hit      = (eval_out == target_q);
  assign last_idx = (idx_q == VEC_W'(N_VEC - 1));

  // NOTE: every next-state signal takes its held value first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    mode_d   = mode_q;
    found_d  = found_q;
    vec_d    = vec_q;
    count_d  = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d = triple_t'(target);
          mode_d   = cnt_mode;
          idx_d    = '0;
          found_d  = 1'b0;
          vec_d    = '0;
          count_d  = '0;
          state_d  = ST_SEARCH;
        end
      end

      ST_SEARCH: begin
        if (abort) begin
          idx_d   = '0;
          found_d = 1'b0;
          vec_d   = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          if (hit) begin
            if (count_q != '1) count_d = count_q + CNT_W'(1);
            if (!found_q) begin
              found_d = 1'b1;
              vec_d   = idx_q;
            end
          end
          // idx stops at the last vector rather than wrapping.
          if ((hit && !mode_q) || last_idx) state_d = ST_DONE;
          else                              idx_d   = idx_q + VEC_W'(1);
        end
      end

      ST_DONE: begin
        if (ack) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      target_q <= '0;
      mode_q   <= 1'b0;
      found_q  <= 1'b0;
      vec_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      found_q  <= found_d;
      vec_q    <= vec_d;
      count_q  <= count_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_SEARCH);
  assign valid = (state_q == ST_DONE);
  assign found = found_q;
  assign vec   = vec_q;
  assign count = count_q;

endmodule
